uart_rx_os: RTL and testbench
=============================

# uart_rx_os

Single-clock, oversampling UART receiver that succeeds the dual-clock UART receive path. Runtime-programmable prescale, parity and stop-bit count; per-frame parity and framing error flags; optional majority-vote bit sampling. It sits between the asynchronous serial pin and the parallel receive consumer, and runs entirely on the oversample clock.

## Interface
- DWIDTH, 8: data bits per frame, legal 5..9, sent LSB first.
- PWIDTH, 6: width of the prescale input.
- clk  in  1  oversample clock; one cycle = one sample tick.
- rst  in  1  asynchronous, active-low reset.
- rx_in  in  1  serial line, idle high, asynchronous to clk.
- prescale  in  PWIDTH  ticks per bit, legal 4..2^PWIDTH-1; P below.
- parity_en  in  1  1 = parity bit follows data.
- parity_type  in  1  0 = even, 1 = odd.
- stop2  in  1  1 = two stop bits expected.
- p_data_rx  out  DWIDTH  last received word; holds until next frame completes.
- data_valid_rx  out  1  one-cycle pulse, frame complete.
- parity_err  out  1  valid only with data_valid_rx.
- stop_err  out  1  valid only with data_valid_rx; any stop sample was 0.
- busy_rx  out  1  high from start detection until frame completes or aborts.

## Operation
- rx_in passes through a 2-flop synchronizer (rx_s); both flops reset to 1.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: when rx_s == 0 -> START, tick counter cnt = 0 in that cycle; prescale, parity_en, parity_type and stop2 latched; changes mid-frame ignored.
- Every bit state: cnt counts 0..P-1, wraps to 0 on bit advance; bit value resolved at cnt == P/2+1 (P/2 floor).
- START: resolved bit 1 -> false start, back to IDLE, no outputs except busy_rx drop. Otherwise -> DATA at wrap.
- DATA: shift resolved bit into MSB of shift register (LSB-first frame); bit counter 0..DWIDTH-1; after last bit -> PARITY if parity_en else STOP.
- PARITY: expected = XOR(data) for even, ~XOR(data) for odd; mismatch sets parity_err.
- STOP: one or two stop bits per latched stop2; any resolved 0 sets stop_err. Frame ends at resolution of last stop bit (mid-bit) to allow resync on back-to-back frames.
- Frame end: p_data_rx, parity_err, stop_err load and data_valid_rx pulses next cycle; FSM returns to IDLE in that same cycle. Data is delivered even when errored.
- No receive buffering: a new frame overwrites p_data_rx; consumer must read within one frame time.

## Timing
- Reset values: p_data_rx = 0, data_valid_rx = 0, parity_err = 0, stop_err = 0, busy_rx = 0, FSM IDLE, cnt = 0.
- Reset mid-frame: frame discarded immediately, no valid pulse; next falling edge after release starts a fresh frame.
- rx_in to rx_s latency: 2 cycles.
- t0 = cycle IDLE sees rx_s == 0; busy_rx high from t0+1.
- L = 1 + DWIDTH + parity_en + stop2 (index of last stop bit). data_valid_rx high in cycle t0 + L*P + P/2 + 2; busy_rx low same cycle.
- Example P=8, DWIDTH=8, no parity, stop2=0: valid at t0+78.
- False start: busy_rx low at t0 + P/2 + 2.

## Configuration
- UART_RX_MAJORITY_EN defined: bit value = majority of rx_s at cnt == P/2-1, P/2, P/2+1; rejects single-tick glitches.
- Undefined: bit value = rx_s at cnt == P/2 only. Resolution point and all output timing identical in both builds.

## Test plan
- P=8, no parity, stop2=0, send 0xAA -> one data_valid_rx pulse at t0+78, p_data_rx=0xAA, both errors 0, busy_rx low after.
- Even parity, 0xAA with parity bit 0 -> parity_err=0; repeat with parity bit 1 -> p_data_rx=0xAA, parity_err=1.
- Odd parity, stop2=1, send 0x55 with parity bit 1 -> parity_err=0, valid at t0+8*11+6 = t0+94; second stop bit driven 0 -> stop_err=1.
- rx_in low for 2 cycles then high -> no data_valid_rx, busy_rx pulses and drops at t0+6, FSM IDLE.
- Reset asserted mid-DATA of 0xF0, released, then send 0x3C -> only one valid pulse, p_data_rx=0x3C.
- With UART_RX_MAJORITY_EN: invert rx_in for one tick at mid of bit 3 in 0x00 -> p_data_rx=0x00; without macro, glitch at cnt==P/2 -> p_data_rx=0x08.

Source files
------------

// File: rtl/uart_rx_os_if.sv
// uart_rx_os_if -- bundle of the serial line, frame configuration and
// receive-side outputs of uart_rx_os.
//   master : drives rx_in / prescale / parity_en / parity_type / stop2,
//            observes p_data_rx / data_valid_rx / parity_err / stop_err / busy_rx
//   slave  : the receiver itself
interface uart_rx_os_if #(
    parameter int DWIDTH = 8,
    parameter int PWIDTH = 6
);
    logic              rx_in;
    logic [PWIDTH-1:0] prescale;
    logic              parity_en;
    logic              parity_type;
    logic              stop2;
    logic [DWIDTH-1:0] p_data_rx;
    logic              data_valid_rx;
    logic              parity_err;
    logic              stop_err;
    logic              busy_rx;

    modport master (
        output rx_in, prescale, parity_en, parity_type, stop2,
        input  p_data_rx, data_valid_rx, parity_err, stop_err, busy_rx
    );

    modport slave (
        input  rx_in, prescale, parity_en, parity_type, stop2,
        output p_data_rx, data_valid_rx, parity_err, stop_err, busy_rx
    );
endinterface

// File: rtl/uart_rx_os.sv
// uart_rx_os -- single-clock oversampling UART receiver.
// One clk cycle is one sample tick; prescale ticks make one bit.
// Ports:
//   clk  : oversample clock
//   rst  : asynchronous active-low reset
//   bus  : uart_rx_os_if.slave (serial line, frame config, received word,
//          valid pulse, parity/stop error flags, busy)
// Build option: define UART_RX_MAJORITY_EN to resolve each bit by majority
// vote of three samples around mid-bit instead of a single mid-bit sample.
// Resolution cycle and all output timing are the same in both builds.
module uart_rx_os #(
    parameter int DWIDTH = 8,
    parameter int PWIDTH = 6
) (
    input logic         clk,
    input logic         rst,
    uart_rx_os_if.slave bus
);
    localparam int BW = 4;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state_q, state_d;
    logic [PWIDTH-1:0] cnt_q, cnt_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DWIDTH-1:0] shreg_q, shreg_d;
    logic [PWIDTH-1:0] pre_q, pre_d;
    logic              par_en_q, par_en_d;
    logic              par_type_q, par_type_d;
    logic              stop2_q, stop2_d;
    logic              perr_acc_q, perr_acc_d;
    logic              serr_acc_q, serr_acc_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic              perr_q, perr_d;
    logic              serr_q, serr_d;
    logic              valid_q, valid_d;

    logic              rx_meta_q, rx_s_q;
    logic              rx_s;
    logic [PWIDTH-1:0] half;
    logic              res, wrap, last_stop, bit_val;
    logic              samp_mid_q;

    // 2-flop synchronizer, idle-high so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx_in;
            rx_s_q    <= rx_meta_q;
        end
    end
    assign rx_s = rx_s_q;

    assign half      = pre_q >> 1;
    assign res       = (cnt_q == half + 1'b1);
    assign wrap      = (cnt_q == pre_q - 1'b1);
    assign last_stop = (bit_cnt_q == BW'(stop2_q));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               samp_mid_q <= 1'b1;
        else if (cnt_q == half) samp_mid_q <= rx_s;
    end

`ifdef UART_RX_MAJORITY_EN
    logic samp_pre_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                      samp_pre_q <= 1'b1;
        else if (cnt_q == half - 1'b1) samp_pre_q <= rx_s;
    end
    // third vote is the live sample in the resolution cycle
    assign bit_val = (samp_pre_q & samp_mid_q) | (samp_pre_q & rx_s) | (samp_mid_q & rx_s);
`else
    assign bit_val = samp_mid_q;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = wrap ? '0 : cnt_q + 1'b1;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        pre_d      = pre_q;
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
        stop2_d    = stop2_q;
        perr_acc_d = perr_acc_q;
        serr_acc_d = serr_acc_q;
        data_d     = data_q;
        perr_d     = perr_q;
        serr_d     = serr_q;
        valid_d    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    // the detect cycle is tick 0 of the start bit
                    state_d    = START;
                    cnt_d      = PWIDTH'(1);
                    bit_cnt_d  = '0;
                    pre_d      = bus.prescale;
                    par_en_d   = bus.parity_en;
                    par_type_d = bus.parity_type;
                    stop2_d    = bus.stop2;
                    perr_acc_d = 1'b0;
                    serr_acc_d = 1'b0;
                end
            end
            START: begin
                if (res && bit_val) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (wrap) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (res) shreg_d = {bit_val, shreg_q[DWIDTH-1:1]};
                if (wrap) begin
                    if (bit_cnt_q == BW'(DWIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                // odd parity flips the expected bit
                if (res)  perr_acc_d = bit_val ^ (^shreg_q) ^ par_type_q;
                if (wrap) state_d    = STOP;
            end
            STOP: begin
                if (res && !bit_val) serr_acc_d = 1'b1;
                if (res && last_stop) begin
                    // end mid-bit so a back-to-back start edge is not missed
                    state_d = IDLE;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    data_d  = shreg_q;
                    perr_d  = perr_acc_q;
                    serr_d  = serr_acc_q | ~bit_val;
                end else if (wrap) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            pre_q      <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            stop2_q    <= 1'b0;
            perr_acc_q <= 1'b0;
            serr_acc_q <= 1'b0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            pre_q      <= pre_d;
            par_en_q   <= par_en_d;
            par_type_q <= par_type_d;
            stop2_q    <= stop2_d;
            perr_acc_q <= perr_acc_d;
            serr_acc_q <= serr_acc_d;
            data_q     <= data_d;
            perr_q     <= perr_d;
            serr_q     <= serr_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.p_data_rx     = data_q;
    assign bus.data_valid_rx = valid_q;
    assign bus.parity_err    = perr_q;
    assign bus.stop_err      = serr_q;
    assign bus.busy_rx       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os -- self-checking bench for uart_rx_os (DWIDTH=8, PWIDTH=6).
// Frames are driven bit by bit on rx_in; a monitor logs every valid pulse
// with its cycle number, and each frame is compared against expectations
// derived from the frame contents and the frame timing rules.
module tb_uart_rx_os;
    localparam int DW = 8;
    localparam int PW = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_rx_os_if #(.DWIDTH(DW), .PWIDTH(PW)) bus ();
    uart_rx_os #(.DWIDTH(DW), .PWIDTH(PW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] d;
        logic       pe, se, busy, busy_prev;
    } ev_t;
    ev_t  evq[$];
    logic busy_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.data_valid_rx === 1'b1)
            evq.push_back('{cyc, bus.p_data_rx, bus.parity_err, bus.stop_err, bus.busy_rx, busy_prev});
        busy_prev = bus.busy_rx;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_cyc(input int t);
        do @(negedge clk); while (cyc < t);
    endtask

    // Drives one frame starting right after a clock edge; c0 is the cycle the
    // start bit first appears on rx_in. gbit >= 0 inverts rx_in for one tick at
    // mid-bit of that frame bit. scramble changes the config inputs mid-frame.
    task automatic drive_frame(input logic [7:0] d, input int p, input bit pe, input bit pt,
                               input bit s2, input bit pbit, input bit [1:0] stops,
                               input int gbit, input bit scramble, output int c0);
        bit bits[12];
        int n;
        bus.prescale    = PW'(p);
        bus.parity_en   = pe;
        bus.parity_type = pt;
        bus.stop2       = s2;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
        n = 9;
        if (pe) begin bits[n] = pbit; n++; end
        bits[n] = stops[0]; n++;
        if (s2) begin bits[n] = stops[1]; n++; end
        @(posedge clk); #1;
        c0 = cyc;
        for (int b = 0; b < n; b++) begin
            if (scramble && b == 2) begin
                bus.prescale    = PW'($urandom_range(4, 63));
                bus.parity_en   = 1'($urandom_range(0, 1));
                bus.parity_type = 1'($urandom_range(0, 1));
                bus.stop2       = 1'($urandom_range(0, 1));
            end
            if (b == n - 1) begin
                bus.prescale    = PW'(p);
                bus.parity_en   = pe;
                bus.parity_type = pt;
                bus.stop2       = s2;
            end
            for (int k = 0; k < p; k++) begin
                bus.rx_in = (b == gbit && k == p / 2) ? ~bits[b] : bits[b];
                @(posedge clk); #1;
            end
        end
        bus.rx_in = 1'b1;
        repeat (2 * p + 8) @(posedge clk);
        #1;
    endtask

    // dt is the valid-pulse cycle measured from t0 (t0 = c0 + 2, synchronizer delay)
    task automatic check_frame(input string nm, input int c0, input int dt,
                               input logic [7:0] ed, input bit ep, input bit es);
        ev_t e;
        chk({nm, " pulses"}, evq.size(), 1);
        if (evq.size() > 0) begin
            e = evq.pop_front();
            chk({nm, " cycle"}, e.cyc - c0, dt + 2);
            chk({nm, " data"}, e.d, ed);
            chk({nm, " parity_err"}, e.pe, ep);
            chk({nm, " stop_err"}, e.se, es);
            chk({nm, " busy@valid"}, e.busy, 0);
            chk({nm, " busy before"}, e.busy_prev, 1);
        end
        chk({nm, " busy after"}, bus.busy_rx, 0);
        evq.delete();
    endtask

    typedef struct {
        logic [7:0] d;
        int         p;
        bit         pe, pt, s2, pbit;
        bit [1:0]   stops;
        int         gbit;
        logic [7:0] ed;
        bit         ep, es;
        int         dt;
    } vec_t;

    initial begin
        vec_t       tv[11];
        logic [7:0] g_exp;
        int         c0, p, L;
        logic [7:0] d;
        bit         pe, pt, s2, pbit, ep, es;
        bit [1:0]   stops;

`ifdef UART_RX_MAJORITY_EN
        g_exp = 8'h00;
`else
        g_exp = 8'h08;
`endif
        //           d      P   pe pt s2 pb stops  gbit  exp    ep es  dt
        tv[0]  = '{8'hAA,  8, 0, 0, 0, 0, 2'b11, -1, 8'hAA, 0, 0, 78};
        tv[1]  = '{8'hAA,  8, 1, 0, 0, 0, 2'b11, -1, 8'hAA, 0, 0, 86};
        tv[2]  = '{8'hAA,  8, 1, 0, 0, 1, 2'b11, -1, 8'hAA, 1, 0, 86};
        tv[3]  = '{8'h55,  8, 1, 1, 1, 1, 2'b11, -1, 8'h55, 0, 0, 94};
        tv[4]  = '{8'h55,  8, 1, 1, 1, 1, 2'b01, -1, 8'h55, 0, 1, 94};
        tv[5]  = '{8'h81,  4, 0, 0, 0, 0, 2'b11, -1, 8'h81, 0, 0, 40};
        tv[6]  = '{8'h3C,  5, 1, 1, 0, 1, 2'b11, -1, 8'h3C, 0, 0, 54};
        tv[7]  = '{8'hFF, 63, 1, 0, 1, 0, 2'b11, -1, 8'hFF, 0, 0, 726};
        tv[8]  = '{8'h00,  8, 0, 0, 0, 0, 2'b11,  4, g_exp, 0, 0, 78};
        tv[9]  = '{8'h00, 12, 0, 0, 0, 0, 2'b11,  4, g_exp, 0, 0, 116};
        tv[10] = '{8'hC3,  7, 0, 0, 0, 0, 2'b10, -1, 8'hC3, 0, 1, 68};

        bus.rx_in       = 1'b1;
        bus.prescale    = PW'(8);
        bus.parity_en   = 1'b0;
        bus.parity_type = 1'b0;
        bus.stop2       = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset p_data_rx", bus.p_data_rx, 0);
        chk("reset data_valid_rx", bus.data_valid_rx, 0);
        chk("reset parity_err", bus.parity_err, 0);
        chk("reset stop_err", bus.stop_err, 0);
        chk("reset busy_rx", bus.busy_rx, 0);

        for (int i = 0; i < 11; i++) begin
            drive_frame(tv[i].d, tv[i].p, tv[i].pe, tv[i].pt, tv[i].s2, tv[i].pbit,
                        tv[i].stops, tv[i].gbit, 1'b0, c0);
            check_frame($sformatf("vec%0d", i), c0, tv[i].dt, tv[i].ed, tv[i].ep, tv[i].es);
        end

        // false start: two low ticks, P=8
        bus.prescale = PW'(8);
        @(posedge clk); #1;
        c0 = cyc;
        bus.rx_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.rx_in = 1'b1;
        wait_cyc(c0 + 3);
        chk("false start busy t0+1", bus.busy_rx, 1);
        wait_cyc(c0 + 7);
        chk("false start busy t0+5", bus.busy_rx, 1);
        wait_cyc(c0 + 8);
        chk("false start busy t0+6", bus.busy_rx, 0);
        repeat (20) @(posedge clk);
        #1;
        chk("false start pulses", evq.size(), 0);
        evq.delete();

        // reset in the middle of the data bits of 0xF0 (low nibble is all zero)
        @(posedge clk); #1;
        bus.rx_in = 1'b0;
        repeat (5 * 8) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.rx_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("mid reset pulses", evq.size(), 0);
        chk("mid reset busy", bus.busy_rx, 0);
        chk("mid reset p_data_rx", bus.p_data_rx, 0);
        evq.delete();
        drive_frame(8'h3C, 8, 0, 0, 0, 0, 2'b11, -1, 1'b0, c0);
        check_frame("after reset", c0, 78, 8'h3C, 0, 0);

        // random frames, config inputs disturbed mid-frame
        for (int r = 0; r < 40; r++) begin
            d     = 8'($urandom);
            p     = $urandom_range(4, 20);
            pe    = 1'($urandom_range(0, 1));
            pt    = 1'($urandom_range(0, 1));
            s2    = 1'($urandom_range(0, 1));
            pbit  = 1'($urandom_range(0, 1));
            stops = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            drive_frame(d, p, pe, pt, s2, pbit, stops, -1, 1'b1, c0);
            L  = 1 + 8 + int'(pe) + int'(s2);
            ep = pe && (pbit != ((^d) ^ pt));
            es = !stops[0] || (s2 && !stops[1]);
            check_frame($sformatf("rnd%0d", r), c0, L * p + p / 2 + 2, d, ep, es);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
